// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive path.
// State encoding, default sizes and the slot-width helper.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_e;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHANNELS = 2;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-CHANNELS slot counter for the TDM demux.
// Supports a synchronous load-to-1 used when a frame starts or realigns.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SW       = clog2(CHANNELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  output logic [SW-1:0] slot,
  output logic          last
);

  localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

  assign last = (slot == LAST_SLOT);

  // Advance one slot per accepted beat, wrapping at the last channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (load) begin
      slot <= SW'(1);
    end else if (en) begin
      if (last) slot <= '0;
      else      slot <= slot + SW'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: steers beats into per-channel shadows and
// publishes whole frames atomically with a one-cycle valid strobe.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      frame_start,
  output logic [WIDTH*CHANNELS-1:0] y,
  output logic                      out_valid,
  output logic                      locked,
  output logic                      sync_err,
  output logic [CNT_W-1:0]          frame_cnt
);

  localparam int SW = clog2(CHANNELS);

  tdm_state_e                state;
  logic [WIDTH-1:0]          shadow [CHANNELS];
  logic [SW-1:0]             slot;
  logic                      last;
  logic                      misalign;
  logic                      cnt_load;
  logic                      cnt_en;
  logic [WIDTH*CHANNELS-1:0] frame_next;

  assign locked   = (state == LOCK);
  assign misalign = frame_start && (slot != '0);
  assign cnt_load = din_valid && frame_start &&
                    ((state == HUNT) || (slot != '0));
  assign cnt_en   = din_valid && (state == LOCK) && !cnt_load;

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SW       (SW)
  ) u_slot (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .load (cnt_load),
    .slot (slot),
    .last (last)
  );

  // Frame as it will look once the current beat lands in its slot.
  always_comb begin
    frame_next = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (SW'(k) == slot) frame_next[k*WIDTH +: WIDTH] = din;
      else                frame_next[k*WIDTH +: WIDTH] = shadow[k];
    end
  end

  // Alignment FSM, shadow capture and registered frame publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      y         <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      frame_cnt <= '0;
      for (int k = 0; k < CHANNELS; k++) shadow[k] <= '0;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_start) begin
              shadow[0] <= din;
              state     <= LOCK;
            end
          end
          LOCK: begin
            if (misalign) begin
              shadow[0] <= din;
              sync_err  <= 1'b1;
            end else begin
              shadow[slot] <= din;
              if (last) begin
                y         <= frame_next;
                out_valid <= 1'b1;
                frame_cnt <= frame_cnt + CNT_W'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
